// File: rtl/pipe_stage_skid_pkg.sv
// rtl/pipe_stage_skid_pkg.sv - shared types, constants and helpers for the pipeline stage
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  localparam int unsigned NOP_WORD = 0;

  // Width needed to hold the delay count itself; never narrower than one bit.
  function automatic int flush_cnt_w(input int delay);
    return (delay < 1) ? 1 : $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - upstream/downstream handshake and control bundle for the stage
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic              i_valid;
  logic              o_ready;
  logic [PC_W-1:0]   i_pc;
  logic [DATA_W-1:0] i_data;
  logic              i_flush;
  logic              i_hold;
  logic              o_valid;
  logic              i_ready;
  logic [PC_W-1:0]   o_pc;
  logic [DATA_W-1:0] o_data;
  logic              o_flush_pend;
  logic [1:0]        o_occupancy;

  modport slave (
    input  i_valid, i_pc, i_data, i_flush, i_hold, i_ready,
    output o_ready, o_valid, o_pc, o_data, o_flush_pend, o_occupancy
  );

  modport master (
    output i_valid, i_pc, i_data, i_flush, i_hold, i_ready,
    input  o_ready, o_valid, o_pc, o_data, o_flush_pend, o_occupancy
  );
endinterface

// File: rtl/pipe_stage_skid_flush_timer.sv
// rtl/pipe_stage_skid_flush_timer.sv - delayed flush counter: i_hold arms, expire fires FLUSH_DELAY edges later
module pipe_flush_timer
  import pipe_pkg::*;
#(
  parameter int FLUSH_DELAY = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_hold,
  input  logic i_flush,
  output logic expire,
  output logic pending
);

  generate
    if (FLUSH_DELAY == 0) begin : g_immediate
      assign expire  = i_hold;
      assign pending = 1'b0;
    end else begin : g_counted
      localparam int CW = flush_cnt_w(FLUSH_DELAY);

      logic [CW-1:0] cnt_q;
      logic          pend_q;

      // Counter reaches 0 on the flushing edge, so the last armed cycle sees 1.
      assign expire  = pend_q && (cnt_q == CW'(1));
      assign pending = pend_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          cnt_q  <= '0;
          pend_q <= 1'b0;
        end else if (i_flush) begin
          cnt_q  <= '0;
          pend_q <= 1'b0;
        end else if (pend_q) begin
          cnt_q <= cnt_q - CW'(1);
          if (expire) pend_q <= 1'b0;
        end else if (i_hold) begin
          cnt_q  <= CW'(FLUSH_DELAY);
          pend_q <= 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - registered-ready pipeline stage with two-entry skid and flush control
// PIPE_STAGE_BUBBLE_ZERO_EN: clear payload/PC to NOP_WORD whenever the stage empties.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int FLUSH_DELAY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  pipe_stage_skid_if.slave  bus
);

`ifdef PIPE_STAGE_BUBBLE_ZERO_EN
  localparam bit BUBBLE_ZERO = 1'b1;
`else
  localparam bit BUBBLE_ZERO = 1'b0;
`endif

  occ_t              occ_q, occ_n;
  logic              ready_q;
  logic [PC_W-1:0]   main_pc_q, skid_pc_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic              accept, drain, flush_eff, timer_expire, timer_pend;
  logic              ld_main_in, ld_main_skid, ld_skid, to_empty, clr;

  pipe_flush_timer #(.FLUSH_DELAY(FLUSH_DELAY)) u_flush_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_hold  (bus.i_hold),
    .i_flush (bus.i_flush),
    .expire  (timer_expire),
    .pending (timer_pend)
  );

  assign accept    = bus.i_valid && ready_q;
  assign drain     = (occ_q != OCC_EMPTY) && bus.i_ready;
  assign flush_eff = bus.i_flush || timer_expire;
  assign clr       = BUBBLE_ZERO && to_empty;

  always_comb begin
    occ_n        = occ_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    to_empty     = 1'b0;
    if (flush_eff) begin
      occ_n    = OCC_EMPTY;
      to_empty = 1'b1;
    end else begin
      case (occ_q)
        OCC_EMPTY: if (accept) begin
          occ_n      = OCC_ONE;
          ld_main_in = 1'b1;
        end
        OCC_ONE: begin
          if (accept && !drain) begin
            occ_n   = OCC_FULL;
            ld_skid = 1'b1;
          end else if (accept && drain) begin
            ld_main_in = 1'b1;
          end else if (drain) begin
            occ_n    = OCC_EMPTY;
            to_empty = 1'b1;
          end
        end
        OCC_FULL: if (drain) begin
          occ_n        = OCC_ONE;
          ld_main_skid = 1'b1;
        end
        default: begin
          occ_n    = OCC_EMPTY;
          to_empty = 1'b1;
        end
      endcase
    end
  end

  // Ready is a flop of the next occupancy so i_ready never reaches o_ready combinationally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ_q   <= OCC_EMPTY;
      ready_q <= 1'b1;
    end else begin
      occ_q   <= occ_n;
      ready_q <= (occ_n != OCC_FULL);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_pc_q   <= '0;
      main_data_q <= '0;
      skid_pc_q   <= '0;
      skid_data_q <= '0;
    end else if (clr) begin
      main_pc_q   <= PC_W'(NOP_WORD);
      main_data_q <= DATA_W'(NOP_WORD);
      skid_pc_q   <= PC_W'(NOP_WORD);
      skid_data_q <= DATA_W'(NOP_WORD);
    end else begin
      if (ld_main_in) begin
        main_pc_q   <= bus.i_pc;
        main_data_q <= bus.i_data;
      end else if (ld_main_skid) begin
        main_pc_q   <= skid_pc_q;
        main_data_q <= skid_data_q;
      end
      if (ld_skid) begin
        skid_pc_q   <= bus.i_pc;
        skid_data_q <= bus.i_data;
      end
    end
  end

  assign bus.o_ready      = ready_q;
  assign bus.o_valid      = (occ_q != OCC_EMPTY);
  assign bus.o_pc         = main_pc_q;
  assign bus.o_data       = main_data_q;
  assign bus.o_flush_pend = timer_pend;
  assign bus.o_occupancy  = occ_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed scoreboard bench for pipe_stage_skid with FLUSH_DELAY=3
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int PW = 32;
  localparam int FD = 3;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  pipe_stage_skid_if #(.DATA_W(DW), .PC_W(PW)) bus ();

  pipe_stage_skid #(.DATA_W(DW), .PC_W(PW), .FLUSH_DELAY(FD)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  logic [63:0] q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check pre-edge outputs against the model, then advance the model.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] data,
                      input logic rdy, input logic fl, input logic hd,
                      input logic fire, input logic pend);
    logic acc, drn;
    bus.i_valid = v;
    bus.i_pc    = pc;
    bus.i_data  = data;
    bus.i_ready = rdy;
    bus.i_flush = fl;
    bus.i_hold  = hd;
    @(negedge i_clk);
    check("occupancy", 64'(bus.o_occupancy), 64'(q.size()));
    check("o_valid", 64'(bus.o_valid), 64'(q.size() != 0));
    check("o_ready", 64'(bus.o_ready), 64'(q.size() != 2));
    check("o_flush_pend", 64'(bus.o_flush_pend), 64'(pend));
    drn = (q.size() != 0) && rdy;
    acc = v && (q.size() != 2);
    if (drn && !(fl || fire)) begin
      check("o_pc", 64'(bus.o_pc), 64'(q[0][63:32]));
      check("o_data", 64'(bus.o_data), 64'(q[0][31:0]));
    end
    @(posedge i_clk);
    if (fl || fire) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back({pc, data});
    end
    #1;
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_pc    = '0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_hold  = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst_o_ready", 64'(bus.o_ready), 64'd1);
    check("rst_o_valid", 64'(bus.o_valid), 64'd0);
    check("rst_o_data", 64'(bus.o_data), 64'd0);
    check("rst_o_pc", 64'(bus.o_pc), 64'd0);
    check("rst_occupancy", 64'(bus.o_occupancy), 64'd0);
    check("rst_flush_pend", 64'(bus.o_flush_pend), 64'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Single transfer
    step(1'b1, 32'h100, 32'h8C010004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure: third push refused while full, then ordered drain
    step(1'b1, 32'hA0, 32'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB0, 32'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC0, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC0, 32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC0, 32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Streaming
    for (int i = 0; i < 16; i++)
      step(1'b1, 32'h2000 + 32'(i * 4), 32'hD000 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Immediate flush while full, offered input discarded
    step(1'b1, 32'h110, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h220, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h999, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_BUBBLE_ZERO_EN
    check("bubble_o_data", 64'(bus.o_data), 64'd0);
`endif
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Immediate flush at occupancy 1 with o_ready high
    step(1'b1, 32'h330, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h999, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Delayed flush: hold at edge E, re-hold ignored, flush at E+3
    step(1'b1, 32'h440, 32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h550, 32'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pending flush cancelled by i_flush at E+1; entry pushed later survives E+3
    step(1'b1, 32'h660, 32'h66, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h770, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Hold and flush together: nothing armed
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while full with a flush pending
    step(1'b1, 32'h880, 32'h88, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h990, 32'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.i_valid = 1'b0;
    bus.i_hold  = 1'b0;
    #1 i_rst_n = 1'b0;
    #1;
    check("arst_o_valid", 64'(bus.o_valid), 64'd0);
    check("arst_o_ready", 64'(bus.o_ready), 64'd1);
    check("arst_occupancy", 64'(bus.o_occupancy), 64'd0);
    check("arst_flush_pend", 64'(bus.o_flush_pend), 64'd0);
    check("arst_o_data", 64'(bus.o_data), 64'd0);
    check("arst_o_pc", 64'(bus.o_pc), 64'd0);
    #1 i_rst_n = 1'b1;
    q.delete();
    step(1'b1, 32'hAA0, 32'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
